// File: rtl/alu_sequencer.sv
// Control front-end for the 32-bit ripple-carry ALU: accepts requests, sequences
// one or two ALU passes, returns the result and keeps the architectural Z/N flags.
module alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_add,
    output logic             alu_inc,
    output logic             alu_neg,
    output logic             alu_sub,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    input  logic             alu_n,
    output logic             flag_z,
    output logic             flag_n
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        FIX  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_INC  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_NEG  = 3'd3;
    localparam logic [2:0] OP_ABSD = 3'd4;
    localparam logic [2:0] OP_PASS = 3'd5;

    // Control word packing: {add, inc, neg, sub}
    localparam logic [3:0] CTRL_FIX = 4'b0011;

    function automatic logic [3:0] decode_ctrl(input logic [2:0] op);
        logic [3:0] ctrl;
        case (op)
            OP_ADD:  ctrl = 4'b1000;
            OP_INC:  ctrl = 4'b0100;
            OP_SUB:  ctrl = 4'b0001;
            OP_NEG:  ctrl = 4'b0011;
            OP_ABSD: ctrl = 4'b0001;
            OP_PASS: ctrl = 4'b0010;
            default: ctrl = 4'b0000;
        endcase
        return ctrl;
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_PASS);
    endfunction

    state_t             state_r, state_s;
    logic [2:0]         op_r, op_s;
    logic [WIDTH-1:0]   alu_a_r, alu_a_s;
    logic [WIDTH-1:0]   alu_b_r, alu_b_s;
    logic [3:0]         ctrl_r, ctrl_s;
    logic [WIDTH-1:0]   res_r, res_s;
    logic               err_r, err_s;
    logic               flag_z_r, flag_z_s;
    logic               flag_n_r, flag_n_s;
    logic               req_ready_r, req_ready_s;
    logic               resp_valid_r, resp_valid_s;

    // Next-state and next-output decode; ALU drives are zero unless a pass is pending.
    always_comb begin
        state_s  = state_r;
        op_s     = op_r;
        alu_a_s  = '0;
        alu_b_s  = '0;
        ctrl_s   = 4'b0000;
        res_s    = res_r;
        err_s    = err_r;
        flag_z_s = flag_z_r;
        flag_n_s = flag_n_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    op_s = req_op;
                    if (op_legal(req_op)) begin
                        state_s = EXEC;
                        alu_a_s = req_a;
                        alu_b_s = req_b;
                        ctrl_s  = decode_ctrl(req_op);
                        err_s   = 1'b0;
                    end else begin
                        state_s = RESP;
                        res_s   = '0;
                        err_s   = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                // A negative ABSD partial result is negated in a second pass
                if ((op_r == OP_ABSD) && alu_n) begin
                    state_s = FIX;
                    alu_a_s = alu_out;
                    ctrl_s  = CTRL_FIX;
                end else begin
                    state_s  = RESP;
                    res_s    = alu_out;
                    err_s    = 1'b0;
                    flag_z_s = alu_z;
                    flag_n_s = alu_n;
                end
            end
            FIX: begin
                state_s  = RESP;
                res_s    = alu_out;
                err_s    = 1'b0;
                flag_z_s = alu_z;
                flag_n_s = alu_n;
            end
            RESP: begin
                if (resp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        req_ready_s  = (state_s == IDLE);
        resp_valid_s = (state_s == RESP);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            op_r         <= 3'd0;
            alu_a_r      <= '0;
            alu_b_r      <= '0;
            ctrl_r       <= 4'b0000;
            res_r        <= '0;
            err_r        <= 1'b0;
            flag_z_r     <= 1'b0;
            flag_n_r     <= 1'b0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            op_r         <= op_s;
            alu_a_r      <= alu_a_s;
            alu_b_r      <= alu_b_s;
            ctrl_r       <= ctrl_s;
            res_r        <= res_s;
            err_r        <= err_s;
            flag_z_r     <= flag_z_s;
            flag_n_r     <= flag_n_s;
            req_ready_r  <= req_ready_s;
            resp_valid_r <= resp_valid_s;
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_data  = res_r;
    assign resp_err   = err_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_add    = ctrl_r[3];
    assign alu_inc    = ctrl_r[2];
    assign alu_neg    = ctrl_r[1];
    assign alu_sub    = ctrl_r[0];
    assign flag_z     = flag_z_r;
    assign flag_n     = flag_n_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU plus a result/latency/flag
// reference model, directed cases followed by randomized requests.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_add;
    logic        alu_inc;
    logic        alu_neg;
    logic        alu_sub;
    logic [31:0] alu_out;
    logic        alu_z;
    logic        alu_n;
    logic        flag_z;
    logic        flag_n;

    int checks   = 0;
    int failures = 0;
    logic mz = 1'b0;
    logic mn = 1'b0;

    alu_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_add(alu_add), .alu_inc(alu_inc), .alu_neg(alu_neg), .alu_sub(alu_sub),
        .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n),
        .flag_z(flag_z), .flag_n(flag_n)
    );

    always #5 clk = ~clk;

    // Behavioural ripple-carry ALU
    logic [31:0] bx;
    always_comb begin
        bx = alu_neg ? 32'd0 : alu_b;
        if (alu_add)      alu_out = alu_a + bx;
        else if (alu_inc) alu_out = bx + 32'd1;
        else if (alu_sub) alu_out = bx - alu_a;
        else              alu_out = alu_a;
    end
    assign alu_z = (alu_out == 32'd0);
    assign alu_n = alu_out[31];

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d = b - a;
        case (op)
            3'd0: return a + b;
            3'd1: return b + 32'd1;
            3'd2: return d;
            3'd3: return 32'd0 - a;
            3'd4: return d[31] ? (32'd0 - d) : d;
            3'd5: return a;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d = b - a;
        if (op > 3'd5) return 1;
        if (op == 3'd4 && d[31]) return 3;
        return 2;
    endfunction

    // Expected {add, inc, neg, sub} during the first pass
    function automatic logic [3:0] exp_ctrl(input logic [2:0] op);
        case (op)
            3'd0: return 4'b1000;
            3'd1: return 4'b0100;
            3'd2: return 4'b0001;
            3'd3: return 4'b0011;
            3'd4: return 4'b0001;
            3'd5: return 4'b0010;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] er;
        int          el;
        logic        illegal;
        int          lat;
        bit          got;
        illegal = (op > 3'd5);
        er = ref_result(op, a, b);
        el = ref_lat(op, a, b);
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = 3'($urandom);
        req_a = $urandom;
        req_b = $urandom;
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 6 && !got; i++) begin
            @(negedge clk);
            if (!illegal && i == 1) begin
                check("exec_ctrl", 32'({alu_add, alu_inc, alu_neg, alu_sub}), 32'(exp_ctrl(op)));
                check("exec_alu_a", alu_a, a);
                check("exec_alu_b", alu_b, b);
                check("busy_ready", 32'(req_ready), 32'd0);
            end
            if (el == 3 && i == 2) begin
                check("fix_ctrl", 32'({alu_add, alu_inc, alu_neg, alu_sub}), 32'b0011);
                check("fix_alu_a", alu_a, b - a);
            end
            if (resp_valid) begin
                got = 1'b1;
                lat = i;
            end
        end
        check("resp_seen", 32'(got), 32'd1);
        check("latency", 32'(lat), 32'(el));
        check("resp_data", resp_data, er);
        check("resp_err", 32'(resp_err), 32'(illegal));
        if (!illegal) begin
            mz = (er == 32'd0);
            mn = er[31];
        end
        check("flag_z", 32'(flag_z), 32'(mz));
        check("flag_n", 32'(flag_n), 32'(mn));
        check("resp_alu_idle", 32'({alu_add, alu_inc, alu_neg, alu_sub}) | alu_a | alu_b, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_data", resp_data, er);
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check("post_valid", 32'(resp_valid), 32'd0);
        check("post_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 3'd0;
        req_a = 32'd0;
        req_b = 32'd0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_flags", 32'({flag_z, flag_n, resp_err}), 32'd0);
        check("rst_alu", 32'({alu_add, alu_inc, alu_neg, alu_sub}) | alu_a | alu_b, 32'd0);
        rst = 1'b0;

        run_op(3'd0, 32'd7, 32'd5, 0);
        run_op(3'd2, 32'd5, 32'd5, 0);
        run_op(3'd7, 32'd9, 32'd9, 0);
        run_op(3'd6, 32'd1, 32'd2, 1);
        run_op(3'd3, 32'd1, 32'd0, 0);
        run_op(3'd4, 32'd5, 32'd3, 0);
        run_op(3'd4, 32'd3, 32'd5, 0);
        run_op(3'd4, 32'd0, 32'h8000_0000, 0);
        run_op(3'd1, 32'd0, 32'hFFFF_FFFF, 10);
        run_op(3'd3, 32'd1, 32'd0, 0);

        // Reset during EXEC of an ADD aborts it and clears the flags
        @(negedge clk);
        req_valid = 1'b1;
        req_op = 3'd0;
        req_a = 32'd100;
        req_b = 32'd200;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_exec_add", 32'(alu_add), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_resp_data", resp_data, 32'd0);
        check("abort_flags", 32'({flag_z, flag_n, resp_err}), 32'd0);
        check("abort_alu", 32'({alu_add, alu_inc, alu_neg, alu_sub}) | alu_a | alu_b, 32'd0);
        mz = 1'b0;
        mn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd5, 32'h1234, 32'hDEAD, 0);

        for (int k = 0; k < 30; k++) begin
            logic [2:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 3'($urandom_range(0, 7));
            if (k % 2 == 0) begin
                ra = 32'($urandom_range(0, 15));
                rb = 32'($urandom_range(0, 15));
            end else begin
                ra = $urandom;
                rb = $urandom;
            end
            run_op(rop, ra, rb, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
